// File: rtl/mips_unified_memory_if.sv
// rtl/mips_unified_memory_if.sv - core bus and loader byte stream between the MIPS core side and the unified memory
interface mips_unified_memory_if;
  logic [31:0] memadd;
  logic [31:0] outdata;
  logic        writeDataEN;
  logic        stopf;
  logic [31:0] memdata;
  logic        cpu_reset;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_last;
  logic        load_ready;
  logic        halted;
  logic        misalign_err;
  logic        oob_err;

  modport master (
    output memadd, outdata, writeDataEN, stopf, load_valid, load_byte, load_last,
    input  memdata, cpu_reset, load_ready, halted, misalign_err, oob_err
  );

  modport slave (
    input  memadd, outdata, writeDataEN, stopf, load_valid, load_byte, load_last,
    output memdata, cpu_reset, load_ready, halted, misalign_err, oob_err
  );
endinterface

// File: rtl/mips_unified_memory.sv
// rtl/mips_unified_memory.sv - unified instruction/data memory with byte-stream loader and halt freeze
module mips_unified_memory #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_WORD = 32'h00000020
) (
  input logic                  clk,
  input logic                  reset,
  mips_unified_memory_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;

  state_t state, state_next;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W:0]   ptr;
  logic [1:0]        byte_idx;
  logic [31:0]       asm_q;
  logic              misalign_q;
  logic              oob_q;

  logic [ADDR_W-1:0] word_addr;
  logic              in_range;
  logic              accept;
  logic              load_full;
  logic              load_commit;
  logic [31:0]       asm_next;
  logic              run_store;
  logic [31:0]       read_word;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  assign word_addr   = bus.memadd[ADDR_W+1:2];
  assign in_range    = (bus.memadd[31:ADDR_W+2] == '0);
  assign accept      = bus.load_valid & bus.load_ready;
  assign load_full   = ptr[ADDR_W];
  assign load_commit = accept & ((byte_idx == 2'd3) | bus.load_last);
  // Byte position is 3-idx, so the first byte lands in bits 31:24 and missing low bytes stay zero.
  assign asm_next    = asm_q | ({24'b0, bus.load_byte} << {~byte_idx, 3'b000});
  assign run_store   = (state == RUN) & bus.writeDataEN;
  assign read_word   = in_range ? mem[word_addr] : 32'h0;

  // Writes are gated by reset so an edge during reset never commits a store or loader word.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = word_addr;
    mem_wdata = bus.outdata;
    if (state == LOAD) begin
      mem_we    = reset & load_commit & ~load_full;
      mem_waddr = ptr[ADDR_W-1:0];
      mem_wdata = asm_next;
    end else begin
      mem_we    = reset & run_store & in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (accept && bus.load_last) state_next = RUN;
      RUN:     if (bus.stopf) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    bus.cpu_reset  = 1'b1;
    bus.load_ready = 1'b0;
    bus.halted     = 1'b0;
    bus.memdata    = NOP_WORD;
    case (state)
      LOAD: bus.load_ready = 1'b1;
      RUN: begin
        bus.cpu_reset = 1'b0;
        bus.memdata   = read_word;
      end
      HALT: begin
        bus.halted  = 1'b1;
        bus.memdata = read_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= '0;
      byte_idx   <= 2'd0;
      asm_q      <= 32'h0;
      misalign_q <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      if (accept) begin
        if (load_full) oob_q <= 1'b1;
        if (load_commit) begin
          asm_q    <= 32'h0;
          byte_idx <= 2'd0;
          if (!load_full) ptr <= ptr + 1'b1;
        end else begin
          asm_q    <= asm_next;
          byte_idx <= byte_idx + 2'd1;
        end
      end
      if (run_store) begin
        if (bus.memadd[1:0] != 2'b00) misalign_q <= 1'b1;
        if (!in_range)                oob_q      <= 1'b1;
      end
    end
  end

  assign bus.misalign_err = misalign_q;
  assign bus.oob_err      = oob_q;
endmodule

// File: doc/mips_unified_memory.md
Name: mips_unified_memory

Overview:
- Word-organised unified instruction/data memory. It is the responder side of the multicycle MIPS core's memory interface.
- It answers the core's address, write-data and write-enable with read data on the same cycle, and commits stores on the clock edge.
- Before execution it takes a program image through a byte-stream loader and holds the core in reset until loading completes.
- After the core raises its halt flag it freezes contents and reports halted status.

Parameters:
- ADDR_W, 8, word-address width; memory holds 2**ADDR_W 32-bit words.
- NOP_WORD, 32'h00000020, value driven on memdata while not in RUN (core-safe no-op).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- memadd  in  32  byte address from core
- outdata  in  32  store data from core
- writeDataEN  in  1  store strobe from core
- stopf  in  1  core halt flag
- memdata  out  32  read data to core
- cpu_reset  out  1  active-high reset to core, asserted while not in RUN
- load_valid  in  1  loader byte valid
- load_byte  in  8  loader byte
- load_last  in  1  marks final byte of image, qualified by load_valid
- load_ready  out  1  loader byte accepted when valid & ready
- halted  out  1  core has halted; memory frozen
- misalign_err  out  1  sticky: access with memadd[1:0] != 0 in RUN
- oob_err  out  1  sticky: address or load beyond 2**ADDR_W words

Behaviour:
- States: LOAD, RUN, HALT. reset low (asynchronous) forces LOAD, load pointer=0, byte index=0, assembly register=0, both error flags=0.
- Reset values of outputs: cpu_reset=1, load_ready=1, halted=0, errors=0, memdata=NOP_WORD. Array contents are not cleared by reset.
- LOAD:
  - Each accepted byte (load_valid & load_ready) shifts into the assembly register, first byte into bits 31:24 (big-endian).
  - On the 4th byte the word is written to mem[ptr], ptr increments and byte index returns to 0.
  - If load_last is set on an accepted byte, the word is written with the remaining low bytes zero-padded, and the state moves to RUN on the next cycle.
  - If ptr == 2**ADDR_W, bytes are still accepted but discarded, and oob_err is set.
  - load_last with no partially assembled word and ptr unchanged (empty image) still moves to RUN.
  - memdata=NOP_WORD in LOAD.
- RUN:
  - cpu_reset=0 and load_ready=0.
  - memdata = mem[memadd[ADDR_W+1:2]] combinationally, with zero latency.
  - If writeDataEN=1, mem[memadd[ADDR_W+1:2]] <= outdata at posedge clk.
  - A read of the address being written in the same cycle returns the old data; new data is visible the next cycle.
  - If memadd[1:0] != 0 while writeDataEN=1, misalign_err is set and the write still uses the truncated word address.
  - If memadd[31:ADDR_W+2] != 0 while writeDataEN=1, oob_err is set, the write is suppressed, and memdata=0 for out-of-range reads.
  - Read-only checks are not flagged, because the core presents ALU results as addresses during non-memory cycles.
  - stopf=1 at posedge moves to HALT. A store coincident with stopf still commits.
- HALT:
  - halted=1, cpu_reset=1, and writeDataEN is ignored.
  - memdata continues to serve reads, so a bench or debugger can dump contents.
  - The block leaves HALT only by reset.
- Reset mid-load: the partial word is lost and words already written remain.
- Reset mid-run: any in-flight write is abandoned and the state returns to LOAD.

Test Plan:
- Load bytes 8C,01,00,04, 00,00,00,20 (last on the 8th byte) -> mem[0]=8C010004, mem[1]=00000020, RUN on the next cycle, cpu_reset falls.
- Load 3 bytes AA,BB,CC with last on CC -> mem[0]=AABBCC00 and RUN.
- In RUN, memadd=0x10, outdata=DEADBEEF, writeDataEN=1 for 1 cycle -> memdata stays at the old value that cycle and reads DEADBEEF the next cycle.
- In RUN, write at memadd=0x12 -> misalign_err=1 and mem[4] written. Write at memadd=0x00001000 (ADDR_W=8) -> oob_err=1, no array change, memdata=0.
- Pulse stopf with a concurrent store to 0x20 -> store committed, halted=1, cpu_reset=1; a later writeDataEN has no effect and reading 0x20 returns the stored word.
- Assert reset low asynchronously mid-load after 2 bytes, then reload 4 bytes -> word 0 holds only the new 4 bytes and errors are clear.
